// File: rtl/issue_queue.sv
// In-order instruction buffer between fetch and the scoreboard; presents the head pre-sliced into register/opcode fields.
// Optional same-cycle empty-queue bypass is enabled by defining ISSUE_QUEUE_BYPASS_EN.
module issue_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_instr,
    input  logic [XLEN-1:0]              in_pc,
    input  logic                         stall,
    input  logic                         kill,
    output logic                         out_valid,
    output logic [XLEN-1:0]              out_instr,
    output logic [XLEN-1:0]              out_pc,
    output logic [4:0]                   rs1,
    output logic [4:0]                   rs2,
    output logic [4:0]                   rd,
    output logic [6:0]                   op_code,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_instr [DEPTH];
    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_bypass;
    logic            w_write;
    logic            w_advance;
    logic [XLEN-1:0] w_head_instr;
    logic [XLEN-1:0] w_head_pc;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full && !kill;
    assign w_push   = in_valid && in_ready;

`ifdef ISSUE_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && w_push;
`else
    assign w_bypass = 1'b0;
`endif

    assign out_valid = !w_empty || w_bypass;
    assign w_pop     = out_valid && !stall && !kill;

    // A bypassed instruction consumed in the same cycle never touches storage or the pointers.
    assign w_write   = w_push && !(w_bypass && w_pop);
    assign w_advance = w_pop && !w_bypass;

    always_comb begin
        w_head_instr = '0;
        w_head_pc    = '0;
        if (w_bypass) begin
            w_head_instr = in_instr;
            w_head_pc    = in_pc;
        end else if (!w_empty) begin
            w_head_instr = r_instr[r_rd_ptr];
            w_head_pc    = r_pc[r_rd_ptr];
        end
    end

    assign out_instr = w_head_instr;
    assign out_pc    = w_head_pc;
    assign rs1       = w_head_instr[19:15];
    assign rs2       = w_head_instr[24:20];
    assign rd        = w_head_instr[11:7];
    assign op_code   = w_head_instr[6:0];
    assign count     = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_advance) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_write) - CW'(w_advance);
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_instr[r_wr_ptr] <= in_instr;
            r_pc[r_wr_ptr]    <= in_pc;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed scoreboard bench for issue_queue: expected entries queue on accepted pushes and are retired on DUT pops.
// Expectations follow ISSUE_QUEUE_BYPASS_EN when it is defined for the build.
module tb_issue_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
`ifdef ISSUE_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              stall;
    logic              kill;
    logic              out_valid;
    logic [XLEN-1:0]   out_instr;
    logic [XLEN-1:0]   out_pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [6:0]        op_code;
    logic [2:0]        count;

    int passCount  = 0;
    int totalCount = 0;

    logic [31:0] expInstr [$];
    logic [31:0] expPc    [$];

    issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .stall     (stall),
        .kill      (kill),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .op_code   (op_code),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Drives one cycle, checks the settled outputs against the model, then retires the cycle in the model.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                                 input logic st, input logic kl, output bit accepted);
        logic        expReady;
        logic        expValid;
        logic        doPush;
        logic        doPop;
        logic [31:0] hInstr;
        logic [31:0] hPc;
        in_valid = v;
        in_instr = ins;
        in_pc    = p;
        stall    = st;
        kill     = kl;
        #2;
        expReady = (expInstr.size() < DEPTH) && !kl;
        expValid = (expInstr.size() != 0) || (BYPASS && expReady && v);
        hInstr = '0;
        hPc    = '0;
        if (expInstr.size() != 0) begin
            hInstr = expInstr[0];
            hPc    = expPc[0];
        end else if (expValid) begin
            hInstr = ins;
            hPc    = p;
        end
        checkOutput("in_ready",  32'(in_ready),  32'(expReady));
        checkOutput("count",     32'(count),     32'(expInstr.size()));
        checkOutput("out_valid", 32'(out_valid), 32'(expValid));
        checkOutput("out_instr", out_instr,      hInstr);
        checkOutput("out_pc",    out_pc,         hPc);
        checkOutput("rs1",       32'(rs1),       32'(hInstr[19:15]));
        checkOutput("rs2",       32'(rs2),       32'(hInstr[24:20]));
        checkOutput("rd",        32'(rd),        32'(hInstr[11:7]));
        checkOutput("op_code",   32'(op_code),   32'(hInstr[6:0]));
        doPush   = v && expReady;
        doPop    = expValid && !st && !kl;
        accepted = doPush;
        @(posedge clk);
        #1;
        if (kl) begin
            expInstr.delete();
            expPc.delete();
        end else begin
            if (doPop && expInstr.size() != 0) begin
                void'(expInstr.pop_front());
                void'(expPc.pop_front());
            end else if (doPop) begin
                doPush = 1'b0;
            end
            if (doPush) begin
                expInstr.push_back(ins);
                expPc.push_back(p);
            end
        end
    endtask

    initial begin
        bit          acc;
        int          pushed;
        logic [31:0] curInstr;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        in_pc    = '0;
        stall    = 1'b0;
        kill     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        checkOutput("reset_count",     32'(count),     32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset_out_instr", out_instr,      32'd0);
        checkOutput("reset_op_code",   32'(op_code),   32'd0);

        $display("[TB] fill under stall");
        applyStimulus(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'h00A00113, 32'h4, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'h002081B3, 32'h8, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'h40000000, 32'hC, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'h00000013, 32'h10, 1'b1, 1'b0, acc);
        checkOutput("full_count",    32'(count),    32'd4);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("held_rd",       32'(rd),       32'd1);
        checkOutput("held_rs1",      32'(rs1),      32'd0);
        checkOutput("held_op_code",  32'(op_code),  32'h13);

        $display("[TB] drain with simultaneous push");
        applyStimulus(1'b1, 32'h00000013, 32'h10, 1'b0, 1'b0, acc);
        checkOutput("push_blocked_full", 32'(acc), 32'd0);
        applyStimulus(1'b1, 32'h00000013, 32'h10, 1'b0, 1'b0, acc);
        checkOutput("push_with_pop", 32'(acc), 32'd1);
        in_valid = 1'b0;
        #1;
        checkOutput("decode_rs1", 32'(rs1),     32'd1);
        checkOutput("decode_rs2", 32'(rs2),     32'd2);
        checkOutput("decode_rd",  32'(rd),      32'd3);
        checkOutput("decode_op",  32'(op_code), 32'h33);
        repeat (4) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

        $display("[TB] kill flush");
        applyStimulus(1'b1, 32'h00100093, 32'h20, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'h00200113, 32'h24, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'h00300193, 32'h28, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'hDEADBEEF, 32'h2C, 1'b0, 1'b1, acc);
        checkOutput("kill_count", 32'(count), 32'd0);
        applyStimulus(1'b1, 32'h00400213, 32'h40, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

        $display("[TB] wrap-around with random stall");
        pushed   = 0;
        curInstr = $urandom;
        for (int cyc = 0; cyc < 100 && (pushed < 10 || expInstr.size() != 0); cyc++) begin
            applyStimulus(pushed < 10, curInstr, 32'h100 + 32'(pushed) * 4,
                          1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) begin
                pushed++;
                curInstr = $urandom;
            end
        end
        checkOutput("wrap_pushed",    32'(pushed), 32'd10);
        checkOutput("wrap_empty_cnt", 32'(count),  32'd0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 32'h00500293, 32'h200, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'h00600313, 32'h204, 1'b1, 1'b0, acc);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expInstr.delete();
        expPc.delete();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'h00700393, 32'h300, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
